// File: rtl/mem_arbiter.sv
// Two-requester round-robin memory arbiter. A single transaction is in flight at a time:
// IDLE picks a winner, ACCESS drives the memory port, RESP returns registered read data.
module mem_arbiter #(
  parameter int AW = 4,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wd0,
  input  logic [DW-1:0] wd1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic [AW-1:0] M_add,
  output logic          M_we,
  output logic          M_re,
  output logic [DW-1:0] M_wd,
  input  logic [DW-1:0] M_rd
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        r_state;
  logic          r_lastWinner;
  logic          r_winner;
  logic          r_we;
  logic          r_gnt0;
  logic          r_gnt1;
  logic          r_rvalid0;
  logic          r_rvalid1;
  logic          r_busy;
  logic [AW-1:0] r_mAdd;
  logic          r_mWe;
  logic          r_mRe;
  logic [DW-1:0] r_mWd;

  logic          w_anyReq;
  logic          w_pick1;

  // Requester 1 wins when alone, or on a tie when requester 0 won last time.
  assign w_anyReq = req0 | req1;
  assign w_pick1  = req1 & (~req0 | ~r_lastWinner);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_lastWinner <= 1'b1;
      r_winner     <= 1'b0;
      r_we         <= 1'b0;
      r_gnt0       <= 1'b0;
      r_gnt1       <= 1'b0;
      r_rvalid0    <= 1'b0;
      r_rvalid1    <= 1'b0;
      r_busy       <= 1'b0;
      r_mAdd       <= '0;
      r_mWe        <= 1'b0;
      r_mRe        <= 1'b0;
      r_mWd        <= '0;
    end else begin
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_mAdd    <= '0;
      r_mWe     <= 1'b0;
      r_mRe     <= 1'b0;
      r_mWd     <= '0;
      case (r_state)
        IDLE: begin
          if (w_anyReq) begin
            r_state      <= ACCESS;
            r_busy       <= 1'b1;
            r_winner     <= w_pick1;
            r_lastWinner <= w_pick1;
            r_we         <= w_pick1 ? we1 : we0;
            r_gnt0       <= ~w_pick1;
            r_gnt1       <= w_pick1;
            r_mAdd       <= w_pick1 ? addr1 : addr0;
            r_mWd        <= w_pick1 ? wd1 : wd0;
            r_mWe        <= w_pick1 ? we1 : we0;
            r_mRe        <= w_pick1 ? ~we1 : ~we0;
          end
        end
        ACCESS: begin
          if (r_we) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state   <= RESP;
            r_rvalid0 <= ~r_winner;
            r_rvalid1 <= r_winner;
          end
        end
        RESP: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // The memory registers its read data, so it is only valid in RESP and is passed straight through.
  assign rdata   = (r_state == RESP) ? M_rd : '0;
  assign gnt0    = r_gnt0;
  assign gnt1    = r_gnt1;
  assign rvalid0 = r_rvalid0;
  assign rvalid1 = r_rvalid1;
  assign busy    = r_busy;
  assign M_add   = r_mAdd;
  assign M_we    = r_mWe;
  assign M_re    = r_mRe;
  assign M_wd    = r_mWd;

endmodule
